// File: rtl/bfp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bfp_pkg
//  Brief    : Shared constants and types for the BFP compression path.
//  Revision : 1.0 - initial release
// ============================================================================
package bfp_pkg;

    localparam int BFP_BEATS_PER_PRB = 6;
    localparam int BFP_IQ_WIDTH_MAX  = 14;
    localparam int BFP_MAX_PRB       = 273;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } bfp_comp_ctrl_state_t;

    // Widths 0 and 15 are not legal; fall back to the widest legal width.
    function automatic logic [3:0] bfp_fix_iq_width(input logic [3:0] w);
        return ((w == 4'd0) || (w == 4'd15)) ? 4'(BFP_IQ_WIDTH_MAX) : w;
    endfunction

    function automatic logic bfp_iq_width_bad(input logic [3:0] w);
        return (w == 4'd0) || (w == 4'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bfp_comp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bfp_comp_ctrl
//  Brief    : Section sequencer feeding the BFP compression gearbox.
//  Revision : 1.0 - initial release
// ============================================================================
module bfp_comp_ctrl
    import bfp_pkg::*;
#(
    parameter int BEATS_PER_PRB = BFP_BEATS_PER_PRB,
    parameter int PRB_W         = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PRB_W-1:0] cmd_num_prb,
    input  logic [3:0]       cmd_iq_width,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             fifo_afull,
    output logic [63:0]      din_data,
    output logic [2:0]       din_state,
    output logic             din_valid,
    output logic             din_sync,
    output logic             din_last,
    output logic [3:0]       ud_iq_width,
    output logic             busy,
    output logic             sec_done,
    output logic             err_bad_width
);

    bfp_comp_ctrl_state_t r_state;
    bfp_comp_ctrl_state_t w_state_nxt;

    logic [PRB_W-1:0] r_num_prb;
    logic [PRB_W-1:0] r_prb_cnt;
    logic [2:0]       r_beat_cnt;
    logic             r_first;

    logic w_cmd_hs;
    logic w_beat_hs;
    logic w_beat_wrap;
    logic w_last_beat;

    assign w_cmd_hs    = cmd_valid && cmd_ready;
    assign w_beat_hs   = s_valid && s_ready;
    assign w_beat_wrap = (r_beat_cnt == 3'(BEATS_PER_PRB - 1));
    assign w_last_beat = w_beat_wrap && (r_prb_cnt == (r_num_prb - PRB_W'(1)));
    assign busy        = (r_state != IDLE);

    // Handshake readies are gated by rst so nothing is accepted while in reset.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        s_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                s_ready = !fifo_afull && !rst;
                if (w_beat_hs && w_last_beat) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Section context: latched on command accept, stepped on every beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_prb     <= '0;
            r_prb_cnt     <= '0;
            r_beat_cnt    <= '0;
            r_first       <= 1'b0;
            ud_iq_width   <= '0;
            err_bad_width <= 1'b0;
        end else if (w_cmd_hs) begin
            r_num_prb   <= (cmd_num_prb == '0) ? PRB_W'(1) : cmd_num_prb;
            r_prb_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_first     <= 1'b1;
            ud_iq_width <= bfp_fix_iq_width(cmd_iq_width);
            if (bfp_iq_width_bad(cmd_iq_width)) begin
                err_bad_width <= 1'b1;
            end
        end else if (w_beat_hs) begin
            r_first <= 1'b0;
            if (w_beat_wrap) begin
                r_beat_cnt <= '0;
                r_prb_cnt  <= r_prb_cnt + PRB_W'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
            end
        end
    end

    // Gearbox-facing outputs; payload fields hold between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_data  <= '0;
            din_state <= '0;
            din_valid <= 1'b0;
            din_sync  <= 1'b0;
            din_last  <= 1'b0;
            sec_done  <= 1'b0;
        end else begin
            din_valid <= w_beat_hs;
            sec_done  <= w_beat_hs && w_last_beat;
            if (w_beat_hs) begin
                din_data  <= s_data;
                din_state <= r_beat_cnt;
                din_sync  <= !r_first;
                din_last  <= w_last_beat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bfp_comp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bfp_comp_ctrl
//  Brief    : Self-checking bench for bfp_comp_ctrl with a section-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bfp_comp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  cmd_num_prb;
    logic [3:0]  cmd_iq_width;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        fifo_afull;
    logic [63:0] din_data;
    logic [2:0]  din_state;
    logic        din_valid;
    logic        din_sync;
    logic        din_last;
    logic [3:0]  ud_iq_width;
    logic        busy;
    logic        sec_done;
    logic        err_bad_width;

    always #5 clk = ~clk;

    bfp_comp_ctrl #(.BEATS_PER_PRB(6), .PRB_W(9)) dut (
        .clk(clk), .rst(rst),
        .cmd_num_prb(cmd_num_prb), .cmd_iq_width(cmd_iq_width),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fifo_afull(fifo_afull),
        .din_data(din_data), .din_state(din_state), .din_valid(din_valid),
        .din_sync(din_sync), .din_last(din_last), .ud_iq_width(ud_iq_width),
        .busy(busy), .sec_done(sec_done), .err_bad_width(err_bad_width)
    );

    typedef struct {
        logic [63:0] data;
        logic [2:0]  st;
        logic        sync;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_cyc = -1000;
    bit          hs_now = 1'b0;
    logic [3:0]  exp_width = 4'd0;
    bit          exp_err = 1'b0;
    bit          chk_idle = 1'b0;
    bit          early = 1'b0;
    int          sec_id = 0;
    int          obs_beats = 0;
    int          obs_lasts = 0;
    logic [2:0]  obs_st[$];
    logic        obs_sy[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Handshake as seen just before the next rising edge.
    always @(negedge clk) begin
        #1;
        hs_now = s_valid && s_ready;
    end

    always @(posedge clk) begin
        bit    hs_p;
        bit    rst_p;
        beat_t e;
        hs_p  = hs_now;
        rst_p = rst;
        #2;
        cyc++;
        check("din_valid_latency", din_valid, hs_p && !rst_p);
        check("err_bad_width", err_bad_width, exp_err);
        if (fifo_afull) check("s_ready_afull", s_ready, 0);
        if (!busy) check("s_ready_idle", s_ready, 0);
        if (busy) check("ud_iq_width_stable", ud_iq_width, exp_width);
        if (chk_idle && !rst) begin
            check("cmd_ready_after_gap", cmd_ready, 1);
            check("busy_after_gap", busy, 0);
        end
        chk_idle = 1'b0;
        if (din_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", din_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("din_data", din_data, e.data);
                check("din_state", din_state, e.st);
                check("din_sync", din_sync, e.sync);
                check("din_last", din_last, e.last);
                check("sec_done", sec_done, e.last);
                if (!e.sync) check("inter_section_gap", (cyc - last_cyc) >= 3, 1);
                obs_beats++;
                obs_st.push_back(din_state);
                obs_sy.push_back(din_sync);
                if (din_last) begin
                    obs_lasts++;
                    last_cyc = cyc;
                    check("cmd_ready_in_gap", cmd_ready, 0);
                    check("busy_in_gap", busy, 1);
                    chk_idle = 1'b1;
                end
            end
        end else begin
            check("sec_done_no_beat", sec_done, 0);
        end
    end

    task automatic clear_obs();
        obs_beats = 0;
        obs_lasts = 0;
        obs_st.delete();
        obs_sy.delete();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; cmd_valid = 1'b0; fifo_afull = 1'b0;
        @(posedge clk);
        exp_q.delete();
        exp_err = 1'b0; exp_width = 4'd0; last_cyc = -1000; chk_idle = 1'b0;
        repeat (n - 1) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_din_valid", din_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_sec_done", sec_done, 0);
        check("rst_err", err_bad_width, 0);
        check("rst_ud_iq_width", ud_iq_width, 0);
        check("rst_din_state", din_state, 0);
        check("rst_din_data", din_data, 0);
        check("rst_din_sync", din_sync, 0);
        check("rst_din_last", din_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("cmd_ready_post_rst", cmd_ready, 1);
    endtask

    task automatic issue_cmd(input int np, input int w);
        int k;
        @(negedge clk);
        cmd_num_prb  = 9'(np);
        cmd_iq_width = 4'(w);
        cmd_valid    = 1'b1;
        fifo_afull   = 1'b0;
        s_valid      = early;
        s_data       = 64'hBAD0_0000_0000_0000;
        k = 0;
        #1;
        while (!cmd_ready && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        exp_width = ((w == 0) || (w == 15)) ? 4'd14 : 4'(w);
        if ((w == 0) || (w == 15)) exp_err = 1'b1;
        sec_id++;
    endtask

    task automatic send_beats(input int np_in, input int bubble, input int afull_pct,
                              input bit afull_trig, input int stop);
        logic [63:0] dq[$];
        beat_t e;
        int np, total, lim, sent, afl, guard;
        np    = (np_in == 0) ? 1 : np_in;
        total = np * 6;
        lim   = (stop > 0) ? stop : total;
        sent  = 0; afl = 0; guard = 0;
        for (int i = 0; i < total; i++) dq.push_back({sec_id[15:0], i[15:0], $urandom()});
        for (int i = 0; i < lim; i++) begin
            e.data = dq[i];
            e.st   = 3'(i % 6);
            e.sync = (i != 0);
            e.last = (i == total - 1);
            exp_q.push_back(e);
        end
        while (sent < lim && guard < total * 10 + 200) begin
            @(negedge clk);
            cmd_valid  = 1'b0;
            guard++;
            fifo_afull = (afl > 0) || ($urandom_range(99) < afull_pct);
            if (afl > 0) afl--;
            s_valid = ($urandom_range(99) >= bubble);
            s_data  = dq[sent];
            @(posedge clk);
            if (hs_now) begin
                sent++;
                if (afull_trig && sent == 3) afl = 5;
            end
        end
        check("beats_accepted", sent, lim);
        @(negedge clk);
        s_valid    = early;
        s_data     = 64'hBAD1_0000_0000_0000;
        fifo_afull = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #3;
        check("model_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; s_valid = 1'b0; s_data = '0;
        fifo_afull = 1'b0; cmd_num_prb = '0; cmd_iq_width = '0;
        do_reset(3);

        // Single PRB, s_valid held high (also during idle/gap).
        early = 1'b1;
        clear_obs();
        issue_cmd(1, 9);
        #2 check("t1_ud_iq_width", ud_iq_width, 9);
        send_beats(1, 0, 0, 1'b0, 0);
        drain();
        check("t1_beats", obs_beats, 6);
        check("t1_lasts", obs_lasts, 1);
        if (obs_st.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_state", obs_st[i], i);
                check("t1_sync", obs_sy[i], (i != 0));
            end
        end

        // Back-to-back commands with a width change.
        clear_obs();
        issue_cmd(2, 9);
        send_beats(2, 0, 0, 1'b0, 0);
        issue_cmd(1, 12);
        #2 check("t2_ud_iq_width", ud_iq_width, 12);
        send_beats(1, 0, 0, 1'b0, 0);
        drain();
        check("t2_beats", obs_beats, 18);
        check("t2_lasts", obs_lasts, 2);
        if (obs_st.size() == 18) begin
            check("t2_wrap_state", obs_st[6], 0);
            check("t2_second_first_sync", obs_sy[12], 0);
        end

        // fifo_afull window after beat 3 of the first PRB.
        early = 1'b0;
        clear_obs();
        issue_cmd(2, 9);
        send_beats(2, 0, 0, 1'b1, 0);
        drain();
        check("t3_beats", obs_beats, 12);
        if (obs_st.size() == 12) check("t3_resume_state", obs_st[3], 3);

        // Illegal widths.
        clear_obs();
        issue_cmd(1, 0);
        #2 check("t4_ud_w0", ud_iq_width, 14);
        check("t4_err_w0", err_bad_width, 1);
        send_beats(1, 0, 0, 1'b0, 0);
        issue_cmd(1, 15);
        #2 check("t4_ud_w15", ud_iq_width, 14);
        send_beats(1, 0, 0, 1'b0, 0);
        drain();
        check("t4_err_sticky", err_bad_width, 1);
        check("t4_beats", obs_beats, 12);

        // Reset in the middle of a section, then a clean section.
        issue_cmd(3, 9);
        send_beats(3, 0, 0, 1'b0, 4);
        do_reset(1);
        clear_obs();
        issue_cmd(1, 9);
        send_beats(1, 0, 0, 1'b0, 0);
        drain();
        check("t5_beats", obs_beats, 6);
        if (obs_st.size() == 6) begin
            for (int i = 0; i < 6; i++) check("t5_state", obs_st[i], i);
        end

        // Maximum section with random bubbles and occasional afull.
        clear_obs();
        issue_cmd(273, $urandom_range(14, 1));
        send_beats(273, 50, 5, 1'b0, 0);
        drain();
        check("t6_beats", obs_beats, 1638);
        check("t6_lasts", obs_lasts, 1);

        // A few random sections, including num_prb=0.
        early = 1'b1;
        for (int s = 0; s < 5; s++) begin
            int np;
            np = $urandom_range(4, 0);
            clear_obs();
            issue_cmd(np, $urandom_range(15, 0));
            send_beats(np, 30, 10, 1'b0, 0);
            drain();
            check("t7_beats", obs_beats, ((np == 0) ? 1 : np) * 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
